// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with two write ports and hardware clear sweep
//
// Purpose: DEPTH x DATA_W register file with NRD combinational read ports and two
//   write ports (port 1 wins on an address clash). After reset, or on clr_req, a
//   sequencer writes zero to every entry, one per clock, while ready is low.
//   Optional: define REGFILE_MP_BYPASS_EN to forward same-cycle write data to reads.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   clr_req   start a clear sweep (ignored while ready=0)
//   ready     1 = operational, 0 = clear sweep in progress
//   we0/wa0/wd0  write port 0
//   we1/wa1/wd1  write port 1 (higher priority)
//   ra        packed read addresses, port i = ra[i*ADDR_W +: ADDR_W]
//   rd        packed read data,      port i = rd[i*DATA_W +: DATA_W]
//   wcollide  registered: previous cycle wrote the same address on both ports

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr_req,
  output logic                  ready,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic                  wcollide
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic run;
  logic w0_ok;
  logic w1_ok;
  logic same_addr;
  logic w0_commit;

  assign run   = (state == ST_RUN);
  assign ready = run;

  // A write is accepted only in RUN and never to the hardwired zero entry, so
  // discarded zero-entry writes cannot raise a collision either.
  assign w0_ok     = run && we0 && !((ZERO_REG != 0) && (wa0 == '0));
  assign w1_ok     = run && we1 && !((ZERO_REG != 0) && (wa1 == '0));
  assign same_addr = (wa0 == wa1);
  assign w0_commit = w0_ok && !(w1_ok && same_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_CLEAR;
      ptr      <= '0;
      wcollide <= 1'b0;
    end else begin
      wcollide <= w0_ok && w1_ok && same_addr;
      if (state == ST_CLEAR) begin
        // ptr wraps back to 0 on the last entry, leaving it ready for the next sweep.
        ptr <= ptr + ADDR_W'(1);
        if (ptr == '1) begin
          state <= ST_RUN;
        end
      end else if (clr_req) begin
        state <= ST_CLEAR;
        ptr   <= '0;
      end
    end
  end

  // Storage has no reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[ptr] <= '0;
    end else begin
      if (w0_commit) begin
        mem[wa0] <= wd0;
      end
      if (w1_ok) begin
        mem[wa1] <= wd1;
      end
    end
  end

  always_comb begin
    rd = '0;
    for (int i = 0; i < NRD; i++) begin
      if (run && !((ZERO_REG != 0) && (ra[i*ADDR_W +: ADDR_W] == '0))) begin
        rd[i*DATA_W +: DATA_W] = mem[ra[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_MP_BYPASS_EN
        // Port 1 is checked last so it wins when both ports hit the same address.
        if (w0_ok && (wa0 == ra[i*ADDR_W +: ADDR_W])) begin
          rd[i*DATA_W +: DATA_W] = wd0;
        end
        if (w1_ok && (wa1 == ra[i*ADDR_W +: ADDR_W])) begin
          rd[i*DATA_W +: DATA_W] = wd1;
        end
`else
        rd[i*DATA_W +: DATA_W] = mem[ra[i*ADDR_W +: ADDR_W]];
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp

module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clr_req;
  logic        we0;
  logic [4:0]  wa0;
  logic [31:0] wd0;
  logic        we1;
  logic [4:0]  wa1;
  logic [31:0] wd1;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [63:0] rd_nz;
  logic        ready;
  logic        ready_nz;
  logic        wcollide;
  logic        wcollide_nz;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .clr_req(clr_req), .ready(ready),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd), .wcollide(wcollide)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(0)) u_dut_nz (
    .clk(clk), .reset_n(reset_n), .clr_req(clr_req), .ready(ready_nz),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd_nz), .wcollide(wcollide_nz)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
    ra = {a1, a0};
    #1;
  endtask

  task automatic idle_writes();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
  endtask

  // Steps until ready rises; returns the number of edges taken (bounded).
  task automatic count_sweep(output int n);
    n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 32; a += 2) begin
      set_ra(5'(a), 5'(a + 1));
      chk(tag, rd, 64'h0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    clr_req = 1'b0;
    idle_writes();
    ra = '0;
    step();
    step();

    // 1. reset sweep: ready low for exactly 32 edges, reads gated to 0
    reset_n = 1'b1;
    #1;
    chk("reset_ready", {63'h0, ready}, 64'h0);
    chk("reset_wcollide", {63'h0, wcollide}, 64'h0);
    set_ra(5'd3, 5'd17);
    chk("reset_rd_gated", rd, 64'h0);
    count_sweep(cnt);
    chk("reset_sweep_len", 64'(cnt), 64'd32);
    check_all_zero("post_reset_zero");

    // 2. two writes to different addresses
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA5A5_0001;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h0000_BEEF;
    step();
    idle_writes();
    set_ra(5'd3, 5'd7);
    chk("dual_write", rd, 64'h0000_BEEF_A5A5_0001);
    chk("dual_no_collide", {63'h0, wcollide}, 64'h0);

    // 3. same-address collision: port 1 wins, flag for one cycle
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1111_1111;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h2222_2222;
    step();
    idle_writes();
    set_ra(5'd9, 5'd3);
    chk("collide_data", rd, 64'hA5A5_0001_2222_2222);
    chk("collide_flag", {63'h0, wcollide}, 64'h1);
    step();
    chk("collide_flag_clears", {63'h0, wcollide}, 64'h0);

    // 4. zero register: discarded with ZERO_REG=1, ordinary with ZERO_REG=0
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
    step();
    idle_writes();
    set_ra(5'd0, 5'd0);
    chk("zero_reg_rd", rd, 64'h0);
    chk("zero_reg_no_collide", {63'h0, wcollide}, 64'h0);
    chk("nonzero_reg_rd", rd_nz, 64'hFFFF_FFFF_FFFF_FFFF);
    // zero-entry writes on both ports must not flag a clash when entry 0 is hardwired
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h2;
    step();
    idle_writes();
    chk("zero_reg_dual_no_collide", {63'h0, wcollide}, 64'h0);
    chk("nonzero_reg_dual_collide", {63'h0, wcollide_nz}, 64'h1);

    // 6. same-cycle read of a write (bypass build-dependent)
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hCAFE_F00D;
    set_ra(5'd5, 5'd9);
`ifdef REGFILE_MP_BYPASS_EN
    chk("bypass_same_cycle", rd[31:0], 64'hCAFE_F00D);
`else
    chk("nobypass_same_cycle", rd[31:0], 64'h0);
`endif
    step();
    idle_writes();
    chk("write_next_cycle", rd, 64'h2222_2222_CAFE_F00D);

    // 5. clr_req sweep: concurrent write performed, writes during sweep lost
    we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h1234_5678;
    clr_req = 1'b1;
    set_ra(5'd3, 5'd12);
    step();
    clr_req = 1'b0;
    idle_writes();
    chk("clr_ready_low", {63'h0, ready}, 64'h0);
    cnt = 1;
    chk("clr_rd_gated", rd, 64'h0);
    while (!ready && cnt < 100) begin
      if (cnt == 5) begin
        we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h0000_DEAD;
        we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h0000_BEAD;
      end else begin
        idle_writes();
      end
      step();
      if (cnt == 5) begin
        chk("clr_write_no_collide", {63'h0, wcollide}, 64'h0);
      end
      cnt++;
    end
    idle_writes();
    chk("clr_sweep_len", 64'(cnt - 1), 64'd32);
    check_all_zero("post_clr_zero");

    // 5b. reset mid-sweep restarts a full-length sweep
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h0BAD_0004;
    step();
    idle_writes();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
    end
    reset_n = 1'b0;
    #2;
    chk("midreset_ready", {63'h0, ready}, 64'h0);
    reset_n = 1'b1;
    count_sweep(cnt);
    chk("midreset_sweep_len", 64'(cnt), 64'd32);
    check_all_zero("post_midreset_zero");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
